// File: rtl/serial_addr_matcher_pkg.sv
// Shared types and constants for the serial address matcher.
// The FSM has exactly two states. The state encoding is also exported as plain localparams.
package serial_addr_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_SHIFT = SHIFT;

  // Station address loaded at reset. It is zero-extended or truncated to ADDR_W at the use site.
  localparam logic [31:0] DEF_ADDR_C = 32'h0000_003F;

endpackage

// File: rtl/serial_addr_matcher_if.sv
// Bit-stream, configuration and result signals of the serial address matcher.
// master = the stream/config source, slave = the matcher.
interface serial_addr_matcher_if #(
  parameter int ADDR_W = 8
);

  // bit_valid qualifies bit_in and frame_start. There is no ready signal:
  // the matcher accepts every bit presented while bit_valid is high, and the
  // source stalls the stream simply by holding bit_valid low.
  logic              bit_valid;
  logic              bit_in;
  logic              frame_start;
  logic              abort;
  logic              cfg_wr;
  logic [ADDR_W-1:0] cfg_addr;
  logic [ADDR_W-1:0] cfg_mask;
  logic              selected;
  logic              bcast;
  logic              addressed;
  logic              busy;
  logic [0:0]        dbg_state;

  modport master (
    output bit_valid, bit_in, frame_start, abort, cfg_wr, cfg_addr, cfg_mask,
    input  selected, bcast, addressed, busy, dbg_state
  );

  modport slave (
    input  bit_valid, bit_in, frame_start, abort, cfg_wr, cfg_addr, cfg_mask,
    output selected, bcast, addressed, busy, dbg_state
  );

endinterface

// File: rtl/serial_addr_matcher_deser.sv
// MSB-first deserializer: a shift register plus a bit counter.
// The counter saturates at ADDR_W.
module serial_deser #(
  parameter  int ADDR_W = 8,
  localparam int CW     = $clog2(ADDR_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [ADDR_W-1:0] data,
  output logic [CW-1:0]     count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(ADDR_W);

  logic [ADDR_W-1:0] r_data;
  logic [CW-1:0]     r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (load) begin
      r_data  <= ADDR_W'(bit_in);
      r_count <= CW'(1);
    end else if (shift_en && (r_count != FULL_CNT)) begin
      r_data  <= {r_data[ADDR_W-2:0], bit_in};
      r_count <= r_count + CW'(1);
    end
  end

  assign data  = r_data;
  assign count = r_count;

endmodule

// File: rtl/serial_addr_matcher.sv
// Serial station-address matcher: assembles an MSB-first address and decides unicast/broadcast match.
// The decision is registered at the edge that accepts the last address bit.
module serial_addr_matcher
  import serial_addr_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter bit          BCAST_EN = 1'b1,
  parameter logic [31:0] DEF_ADDR = DEF_ADDR_C
) (
  input logic                 clk,
  input logic                 rst,
  serial_addr_matcher_if.slave bus
);

  localparam int              CW       = $clog2(ADDR_W + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(ADDR_W - 1);
  localparam logic [ADDR_W-1:0] RST_ADDR = DEF_ADDR[ADDR_W-1:0];

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cfg_addr;
  logic [ADDR_W-1:0] r_cfg_mask;
  logic [ADDR_W-1:0] r_addr_q;
  logic [ADDR_W-1:0] r_mask_q;
  logic              r_selected;
  logic              r_bcast;
  logic              r_addressed;

  logic              w_start;
  logic              w_shift_en;
  logic              w_last;
  logic              w_deser_rst;
  logic [ADDR_W-1:0] w_data;
  logic [CW-1:0]     w_count;
  logic [ADDR_W-1:0] w_assembled;
  logic              w_ucast_hit;
  logic              w_bcast_hit;

  // Priority is rst > abort > frame_start > ordinary shift. A frame_start is accepted in either state.
  assign w_start     = bus.bit_valid && bus.frame_start && !bus.abort;
  assign w_shift_en  = (r_state == ST_SHIFT) && bus.bit_valid && !bus.frame_start && !bus.abort;
  assign w_last      = w_shift_en && (w_count == LAST_CNT);
  assign w_deser_rst = rst || bus.abort;

  serial_deser #(
    .ADDR_W (ADDR_W)
  ) u_deser (
    .clk      (clk),
    .rst      (w_deser_rst),
    .load     (w_start),
    .shift_en (w_shift_en),
    .bit_in   (bus.bit_in),
    .data     (w_data),
    .count    (w_count)
  );

  // Compare against the address as it will look after the final shift, so the decision lands one edge after the last bit.
  assign w_assembled = (w_data << 1) | ADDR_W'(bus.bit_in);
  assign w_ucast_hit = (((w_assembled ^ r_addr_q) & ~r_mask_q) == '0);
  assign w_bcast_hit = BCAST_EN && (&w_assembled);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cfg_addr  <= RST_ADDR;
      r_cfg_mask  <= '0;
      r_addr_q    <= RST_ADDR;
      r_mask_q    <= '0;
      r_selected  <= 1'b0;
      r_bcast     <= 1'b0;
      r_addressed <= 1'b0;
    end else begin
      r_selected <= 1'b0;
      r_bcast    <= 1'b0;
      if (bus.cfg_wr) begin
        r_cfg_addr <= bus.cfg_addr;
        r_cfg_mask <= bus.cfg_mask;
      end
      if (bus.abort) begin
        r_state     <= ST_IDLE;
        r_addressed <= 1'b0;
      end else if (w_start) begin
        // Snapshot the config registers so that a mid-frame cfg_wr only affects the next frame.
        r_state     <= ST_SHIFT;
        r_addressed <= 1'b0;
        r_addr_q    <= r_cfg_addr;
        r_mask_q    <= r_cfg_mask;
      end else if (w_last) begin
        r_state <= ST_IDLE;
        if (w_bcast_hit) begin
          r_bcast     <= 1'b1;
          r_addressed <= 1'b1;
        end else if (w_ucast_hit) begin
          r_selected  <= 1'b1;
          r_addressed <= 1'b1;
        end
      end
    end
  end

  assign bus.selected  = r_selected;
  assign bus.bcast     = r_bcast;
  assign bus.addressed = r_addressed;
  assign bus.busy      = (r_state == ST_SHIFT);
  assign bus.dbg_state = r_state;

endmodule
